// File: rtl/jtpopeye_dma_pkg.sv
// Shared types and constants for the video-DMA host side of the main board.
package jtpopeye_dma_pkg;

  localparam int              DMA_AW       = 10;
  localparam logic [10:0]     DMA_BASE_DEF = 11'h400;
  localparam logic [DMA_AW-1:0] RD_CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2,
    ST_DRAIN = 2'd3
  } dma_state_e;

  function automatic logic [DMA_AW-1:0] sat_inc(input logic [DMA_AW-1:0] v);
    if (v == RD_CNT_MAX) begin
      return v;
    end else begin
      return v + 10'd1;
    end
  endfunction

endpackage

// File: rtl/jtpopeye_dma_host_if.sv
// Bus bundle between video DMA, Z80 core, work RAM and the DMA host.
interface jtpopeye_dma_host_if #(parameter int RAM_AW = 11) ();
  import jtpopeye_dma_pkg::*;

  logic                busrq_n;
  logic                busak_n;
  logic [DMA_AW-1:0]   AD_DMA;
  logic                dma_cs;
  logic [7:0]          DD_DMA;
  logic                cpu_busrq_n;
  logic                cpu_busak_n;
  logic [RAM_AW-1:0]   cpu_addr;
  logic [7:0]          cpu_dout;
  logic                cpu_ram_cs;
  logic                cpu_wr_n;
  logic [RAM_AW-1:0]   ram_addr;
  logic [7:0]          ram_din;
  logic                ram_we;
  logic [7:0]          ram_dout;

  modport slave (
    input  busrq_n, AD_DMA, dma_cs, cpu_busak_n, cpu_addr, cpu_dout,
           cpu_ram_cs, cpu_wr_n, ram_dout,
    output busak_n, DD_DMA, cpu_busrq_n, ram_addr, ram_din, ram_we
  );

  modport master (
    output busrq_n, AD_DMA, dma_cs, cpu_busak_n, cpu_addr, cpu_dout,
           cpu_ram_cs, cpu_wr_n, ram_dout,
    input  busak_n, DD_DMA, cpu_busrq_n, ram_addr, ram_din, ram_we
  );

endinterface

// File: rtl/jtpopeye_dma_rammux.sv
// Work-RAM port owner select plus the DMA address/read-data pipeline.
module jtpopeye_dma_rammux
  import jtpopeye_dma_pkg::*;
#(
  parameter int                RAM_AW   = 11,
  parameter logic [RAM_AW-1:0] DMA_BASE = RAM_AW'(DMA_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dma_owner,
  input  logic              i_rd_accept,
  input  logic [DMA_AW-1:0] i_ad_dma,
  input  logic              i_cpu_cen,
  input  logic [RAM_AW-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_dout,
  input  logic              i_cpu_ram_cs,
  input  logic              i_cpu_wr_n,
  input  logic [7:0]        i_ram_dout,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [7:0]        o_ram_din,
  output logic              o_ram_we,
  output logic [7:0]        o_dd_dma
);

  logic [RAM_AW-1:0] r_dma_addr;
  logic              r_rd_v1;
  logic              r_rd_v2;
  logic [7:0]        r_dd;

  // v1 marks the address cycle, v2 the cycle RAM data is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dma_addr <= '0;
      r_rd_v1    <= 1'b0;
      r_rd_v2    <= 1'b0;
      r_dd       <= 8'h00;
    end else begin
      r_rd_v1 <= i_rd_accept;
      r_rd_v2 <= r_rd_v1;
      if (i_rd_accept) r_dma_addr <= DMA_BASE + RAM_AW'(i_ad_dma);
      if (r_rd_v2)     r_dd       <= i_ram_dout;
    end
  end

  always_comb begin
    o_ram_din = i_cpu_dout;
    if (i_dma_owner) begin
      o_ram_addr = r_dma_addr;
      o_ram_we   = 1'b0;
    end else begin
      o_ram_addr = i_cpu_addr;
      o_ram_we   = i_cpu_ram_cs & ~i_cpu_wr_n & i_cpu_cen;
    end
  end

  assign o_dd_dma = r_dd;

endmodule

// File: rtl/jtpopeye_dma_host.sv
// CPU-side responder for the video DMA BUSRQ/BUSAK handshake; owns work RAM
// while the Z80 has released the bus.
module jtpopeye_dma_host
  import jtpopeye_dma_pkg::*;
#(
  parameter int                RAM_AW    = 11,
  parameter logic [RAM_AW-1:0] DMA_BASE  = RAM_AW'(DMA_BASE_DEF),
  parameter int                DRAIN_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cpu_cen,
  jtpopeye_dma_host_if.slave      bus,
  output logic                    o_dma_owner,
  output logic [DMA_AW-1:0]       o_dma_rd_cnt
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  dma_state_e        r_state, w_state_nxt;
  logic              r_busak_n, w_busak_n_nxt;
  logic              r_cpu_busrq_n, w_cpu_busrq_n_nxt;
  logic              r_owner, w_owner_nxt;
  logic [DMA_AW-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic [DCW-1:0]    r_drain, w_drain_nxt;
  logic              w_rd_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busak_n     <= 1'b1;
      r_cpu_busrq_n <= 1'b1;
      r_owner       <= 1'b0;
      r_rd_cnt      <= '0;
      r_drain       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_busak_n     <= w_busak_n_nxt;
      r_cpu_busrq_n <= w_cpu_busrq_n_nxt;
      r_owner       <= w_owner_nxt;
      r_rd_cnt      <= w_rd_cnt_nxt;
      r_drain       <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_busak_n_nxt     = r_busak_n;
    w_cpu_busrq_n_nxt = r_cpu_busrq_n;
    w_owner_nxt       = r_owner;
    w_rd_cnt_nxt      = r_rd_cnt;
    w_drain_nxt       = r_drain;
    w_rd_accept       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.busrq_n) begin
          w_state_nxt       = ST_REQ;
          w_cpu_busrq_n_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus.busrq_n) begin
          w_state_nxt       = ST_IDLE;
          w_cpu_busrq_n_nxt = 1'b1;
        end else if (i_cpu_cen && !bus.cpu_busak_n) begin
          // RAM ownership is taken here; acknowledge follows from GRANT
          w_state_nxt  = ST_GRANT;
          w_owner_nxt  = 1'b1;
          w_rd_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        w_rd_accept = bus.dma_cs;
        if (bus.busrq_n) begin
          w_state_nxt   = ST_DRAIN;
          w_busak_n_nxt = 1'b1;
          w_drain_nxt   = '0;
        end else begin
          w_busak_n_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_rd_accept = bus.dma_cs;
        if (!bus.busrq_n) begin
          w_state_nxt   = ST_GRANT;
          w_busak_n_nxt = 1'b0;
        end else if (r_drain == DCW'(DRAIN_CYC - 1)) begin
          w_state_nxt       = ST_IDLE;
          w_cpu_busrq_n_nxt = 1'b1;
          w_owner_nxt       = 1'b0;
        end else begin
          w_drain_nxt = r_drain + 1'b1;
        end
      end
      default: begin
        w_state_nxt       = ST_IDLE;
        w_busak_n_nxt     = 1'b1;
        w_cpu_busrq_n_nxt = 1'b1;
        w_owner_nxt       = 1'b0;
      end
    endcase
    if (w_rd_accept) w_rd_cnt_nxt = sat_inc(r_rd_cnt);
  end

  jtpopeye_dma_rammux #(
    .RAM_AW   (RAM_AW),
    .DMA_BASE (DMA_BASE)
  ) u_rammux (
    .clk          (clk),
    .rst          (rst),
    .i_dma_owner  (r_owner),
    .i_rd_accept  (w_rd_accept),
    .i_ad_dma     (bus.AD_DMA),
    .i_cpu_cen    (i_cpu_cen),
    .i_cpu_addr   (bus.cpu_addr),
    .i_cpu_dout   (bus.cpu_dout),
    .i_cpu_ram_cs (bus.cpu_ram_cs),
    .i_cpu_wr_n   (bus.cpu_wr_n),
    .i_ram_dout   (bus.ram_dout),
    .o_ram_addr   (bus.ram_addr),
    .o_ram_din    (bus.ram_din),
    .o_ram_we     (bus.ram_we),
    .o_dd_dma     (bus.DD_DMA)
  );

  assign bus.busak_n     = r_busak_n;
  assign bus.cpu_busrq_n = r_cpu_busrq_n;
  assign o_dma_owner     = r_owner;
  assign o_dma_rd_cnt    = r_rd_cnt;

endmodule

// File: tb/tb_jtpopeye_dma_host.sv
// Directed bench for jtpopeye_dma_host: handshake, reads, wrap, drain, reset.
module tb_jtpopeye_dma_host;

  logic       clk;
  logic       rst;
  logic       cpu_cen;
  logic       dma_owner0, dma_owner1;
  logic [9:0] rd_cnt0, rd_cnt1;
  logic [7:0] mem [2048];
  int         n_vec;
  int         n_err;

  jtpopeye_dma_host_if #(.RAM_AW(11)) bus0 ();
  jtpopeye_dma_host_if #(.RAM_AW(11)) bus1 ();

  jtpopeye_dma_host #(.RAM_AW(11), .DMA_BASE(11'h400), .DRAIN_CYC(2)) dut (
    .clk (clk), .rst (rst), .i_cpu_cen (cpu_cen), .bus (bus0),
    .o_dma_owner (dma_owner0), .o_dma_rd_cnt (rd_cnt0)
  );

  jtpopeye_dma_host #(.RAM_AW(11), .DMA_BASE(11'h7FF), .DRAIN_CYC(2)) dut_wrap (
    .clk (clk), .rst (rst), .i_cpu_cen (cpu_cen), .bus (bus1),
    .o_dma_owner (dma_owner1), .o_dma_rd_cnt (rd_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous work RAM, one clock read latency
  always @(posedge clk) begin
    if (bus0.ram_we) mem[bus0.ram_addr] <= bus0.ram_din;
    bus0.ram_dout <= mem[bus0.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_grant();
    bus0.busrq_n = 1'b0;
    bus0.cpu_busak_n = 1'b0;
    cpu_cen = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    bus0.cpu_addr = a; bus0.cpu_dout = d;
    bus0.cpu_ram_cs = 1'b1; bus0.cpu_wr_n = 1'b0;
    tick();
    bus0.cpu_ram_cs = 1'b0; bus0.cpu_wr_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (bus0.busak_n !== 1'b1 || bus0.cpu_busrq_n !== 1'b1 || bus0.DD_DMA !== 8'h00 ||
        dma_owner0 !== 1'b0 || rd_cnt0 !== 10'd0 || bus0.ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset: busak_n=%b busrq_n=%b dd=%h own=%b cnt=%0d we=%b, want 1 1 00 0 0 0",
               bus0.busak_n, bus0.cpu_busrq_n, bus0.DD_DMA, dma_owner0, rd_cnt0, bus0.ram_we);
    end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    bus0.cpu_addr = 11'h405; bus0.cpu_dout = 8'hA5;
    bus0.cpu_ram_cs = 1'b1; bus0.cpu_wr_n = 1'b0;
    #1;
    n_vec++;
    if (bus0.ram_we !== 1'b1 || bus0.ram_addr !== 11'h405) begin
      n_err++;
      $display("FAIL cpu_we: we=%b addr=%h, want 1 405", bus0.ram_we, bus0.ram_addr);
    end
    tick();
    bus0.cpu_ram_cs = 1'b0; bus0.cpu_wr_n = 1'b1;
    cpu_write(11'h406, 8'h5A);
    tick();
    n_vec++;
    if (mem[11'h405] !== 8'hA5 || mem[11'h406] !== 8'h5A) begin
      n_err++;
      $display("FAIL preload: mem405=%h mem406=%h, want a5 5a", mem[11'h405], mem[11'h406]);
    end
  endtask

  task automatic test_spurious_busak();
    bus0.cpu_busak_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (dma_owner0 !== 1'b0 || bus0.cpu_busrq_n !== 1'b1 || bus0.busak_n !== 1'b1) begin
      n_err++;
      $display("FAIL spurious_busak: own=%b busrq_n=%b busak_n=%b, want 0 1 1",
               dma_owner0, bus0.cpu_busrq_n, bus0.busak_n);
    end
    bus0.cpu_busak_n = 1'b1;
  endtask

  task automatic test_grant();
    bus0.busrq_n = 1'b0;
    tick();
    n_vec++;
    if (bus0.cpu_busrq_n !== 1'b0 || bus0.busak_n !== 1'b1) begin
      n_err++;
      $display("FAIL grant_req: busrq_n=%b busak_n=%b, want 0 1", bus0.cpu_busrq_n, bus0.busak_n);
    end
    // cen on i=0,2,4; BUSAK drops before the 3rd cen but only counts on it
    for (int i = 0; i < 5; i++) begin
      cpu_cen = (i % 2 == 0);
      if (i == 3) bus0.cpu_busak_n = 1'b0;
      tick();
      if (i < 4) begin
        n_vec++;
        if (dma_owner0 !== 1'b0) begin
          n_err++;
          $display("FAIL grant_early: cycle %0d own=%b, want 0", i, dma_owner0);
        end
      end
    end
    cpu_cen = 1'b1;
    n_vec++;
    if (dma_owner0 !== 1'b1 || bus0.busak_n !== 1'b1 || rd_cnt0 !== 10'd0) begin
      n_err++;
      $display("FAIL grant_owner: own=%b busak_n=%b cnt=%0d, want 1 1 0",
               dma_owner0, bus0.busak_n, rd_cnt0);
    end
    tick();
    n_vec++;
    if (bus0.busak_n !== 1'b0 || dma_owner0 !== 1'b1) begin
      n_err++;
      $display("FAIL grant_ack: busak_n=%b own=%b, want 0 1", bus0.busak_n, dma_owner0);
    end
  endtask

  task automatic test_dma_read();
    bus0.AD_DMA = 10'd5; bus0.dma_cs = 1'b1;
    tick();
    bus0.dma_cs = 1'b0;
    n_vec++;
    if (bus0.ram_addr !== 11'h405 || rd_cnt0 !== 10'd1) begin
      n_err++;
      $display("FAIL read_addr: addr=%h cnt=%0d, want 405 1", bus0.ram_addr, rd_cnt0);
    end
    tick();
    n_vec++;
    if (bus0.DD_DMA !== 8'h00) begin
      n_err++;
      $display("FAIL read_lat: dd=%h one clk after strobe, want 00", bus0.DD_DMA);
    end
    tick();
    n_vec++;
    if (bus0.DD_DMA !== 8'hA5) begin
      n_err++;
      $display("FAIL read_data: dd=%h, want a5", bus0.DD_DMA);
    end
    bus0.AD_DMA = 10'd6; bus0.dma_cs = 1'b1;
    tick();
    bus0.AD_DMA = 10'd5;
    tick();
    bus0.dma_cs = 1'b0;
    n_vec++;
    if (rd_cnt0 !== 10'd3) begin
      n_err++;
      $display("FAIL b2b_cnt: cnt=%0d, want 3", rd_cnt0);
    end
    tick();
    n_vec++;
    if (bus0.DD_DMA !== 8'h5A) begin
      n_err++;
      $display("FAIL b2b_first: dd=%h, want 5a", bus0.DD_DMA);
    end
    tick();
    tick();
    n_vec++;
    if (bus0.DD_DMA !== 8'hA5) begin
      n_err++;
      $display("FAIL b2b_hold: dd=%h, want a5", bus0.DD_DMA);
    end
    bus0.cpu_addr = 11'h020; bus0.cpu_dout = 8'h77;
    bus0.cpu_ram_cs = 1'b1; bus0.cpu_wr_n = 1'b0;
    #1;
    n_vec++;
    if (bus0.ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_drop: we=%b while DMA owns RAM, want 0", bus0.ram_we);
    end
    tick();
    bus0.cpu_ram_cs = 1'b0; bus0.cpu_wr_n = 1'b1;
  endtask

  task automatic test_wrap();
    bus1.busrq_n = 1'b0; bus1.cpu_busak_n = 1'b0;
    tick();
    tick();
    tick();
    bus1.AD_DMA = 10'd2; bus1.dma_cs = 1'b1;
    tick();
    bus1.dma_cs = 1'b0;
    n_vec++;
    if (bus1.ram_addr !== 11'h001 || dma_owner1 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap: addr=%h own=%b, want 001 1", bus1.ram_addr, dma_owner1);
    end
  endtask

  task automatic test_release();
    bus0.busrq_n = 1'b1;
    tick();
    n_vec++;
    if (bus0.busak_n !== 1'b1 || dma_owner0 !== 1'b1 || bus0.cpu_busrq_n !== 1'b0) begin
      n_err++;
      $display("FAIL rel_ack: busak_n=%b own=%b busrq_n=%b, want 1 1 0",
               bus0.busak_n, dma_owner0, bus0.cpu_busrq_n);
    end
    tick();
    n_vec++;
    if (dma_owner0 !== 1'b1 || bus0.cpu_busrq_n !== 1'b0) begin
      n_err++;
      $display("FAIL rel_drain: own=%b busrq_n=%b, want 1 0", dma_owner0, bus0.cpu_busrq_n);
    end
    tick();
    n_vec++;
    if (dma_owner0 !== 1'b0 || bus0.cpu_busrq_n !== 1'b1) begin
      n_err++;
      $display("FAIL rel_done: own=%b busrq_n=%b, want 0 1", dma_owner0, bus0.cpu_busrq_n);
    end
    bus0.cpu_busak_n = 1'b1;
    cpu_write(11'h010, 8'h3C);
    tick();
    n_vec++;
    if (mem[11'h010] !== 8'h3C || mem[11'h020] === 8'h77) begin
      n_err++;
      $display("FAIL rel_cpu_wr: mem010=%h mem020=%h, want 3c and not 77",
               mem[11'h010], mem[11'h020]);
    end
  endtask

  task automatic test_rerequest();
    logic rose;
    rose = 1'b0;
    do_grant();
    bus0.AD_DMA = 10'd5; bus0.dma_cs = 1'b1;
    tick();
    tick();
    tick();
    bus0.dma_cs = 1'b0;
    bus0.busrq_n = 1'b1;
    tick();
    if (bus0.cpu_busrq_n !== 1'b0) rose = 1'b1;
    bus0.busrq_n = 1'b0;
    tick();
    if (bus0.cpu_busrq_n !== 1'b0) rose = 1'b1;
    n_vec++;
    if (bus0.busak_n !== 1'b0 || rd_cnt0 !== 10'd3 || rose) begin
      n_err++;
      $display("FAIL rereq: busak_n=%b cnt=%0d busrq_rose=%b, want 0 3 0",
               bus0.busak_n, rd_cnt0, rose);
    end
    tick();
    tick();
    n_vec++;
    if (dma_owner0 !== 1'b1 || bus0.cpu_busrq_n !== 1'b0) begin
      n_err++;
      $display("FAIL rereq_hold: own=%b busrq_n=%b, want 1 0", dma_owner0, bus0.cpu_busrq_n);
    end
  endtask

  task automatic test_reset_midgrant();
    bus0.AD_DMA = 10'd5; bus0.dma_cs = 1'b1;
    for (int i = 0; i < 497; i++) tick();
    bus0.dma_cs = 1'b0;
    tick();
    tick();
    n_vec++;
    if (rd_cnt0 !== 10'd500 || bus0.DD_DMA !== 8'hA5) begin
      n_err++;
      $display("FAIL pre_rst: cnt=%0d dd=%h, want 500 a5", rd_cnt0, bus0.DD_DMA);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (bus0.busak_n !== 1'b1 || bus0.cpu_busrq_n !== 1'b1 || dma_owner0 !== 1'b0 ||
        rd_cnt0 !== 10'd0 || bus0.DD_DMA !== 8'h00) begin
      n_err++;
      $display("FAIL rst_grant: busak_n=%b busrq_n=%b own=%b cnt=%0d dd=%h, want 1 1 0 0 00",
               bus0.busak_n, bus0.cpu_busrq_n, dma_owner0, rd_cnt0, bus0.DD_DMA);
    end
  endtask

  task automatic test_saturate();
    do_grant();
    bus0.AD_DMA = 10'd5; bus0.dma_cs = 1'b1;
    for (int i = 0; i < 1030; i++) tick();
    bus0.dma_cs = 1'b0;
    n_vec++;
    if (rd_cnt0 !== 10'd1023) begin
      n_err++;
      $display("FAIL saturate: cnt=%0d, want 1023", rd_cnt0);
    end
    tick();
    tick();
    n_vec++;
    if (bus0.DD_DMA !== 8'hA5) begin
      n_err++;
      $display("FAIL sat_data: dd=%h, want a5", bus0.DD_DMA);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    cpu_cen = 1'b1;
    bus0.busrq_n = 1'b1; bus0.AD_DMA = 10'd0; bus0.dma_cs = 1'b0;
    bus0.cpu_busak_n = 1'b1; bus0.cpu_addr = 11'h000; bus0.cpu_dout = 8'h00;
    bus0.cpu_ram_cs = 1'b0; bus0.cpu_wr_n = 1'b1;
    bus1.busrq_n = 1'b1; bus1.AD_DMA = 10'd0; bus1.dma_cs = 1'b0;
    bus1.cpu_busak_n = 1'b1; bus1.cpu_addr = 11'h000; bus1.cpu_dout = 8'h00;
    bus1.cpu_ram_cs = 1'b0; bus1.cpu_wr_n = 1'b1; bus1.ram_dout = 8'h00;
    test_reset();
    test_preload();
    test_spurious_busak();
    test_grant();
    test_dma_read();
    test_wrap();
    test_release();
    test_rerequest();
    test_reset_midgrant();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
